// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared state encoding, digit geometry and hex segment patterns for the scan controller
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEG_W      = 7;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

endpackage

// File: rtl/digit_scan_ctrl_bcd_to_seg7.sv
// bcd_to_seg7: combinational hex digit to seven-segment pattern encoder
module bcd_to_seg7
  import digit_scan_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  // Map each hex value to its lit segments
  always_comb begin
    case (digit)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 4-digit seven-segment scan controller with blanking gaps and frame-synchronous double buffering; LEADING_ZERO_BLANK_EN enables leading-zero suppression
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  output logic                          a,
  output logic                          b,
  output logic                          en,
  output logic [SEG_W-1:0]              seg,
  output logic                          dp,
  output logic                          frame_done,
  output logic                          load_ack
);

  state_t                          state_q, state_d;
  logic [1:0]                      idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_DIGITS*DIGIT_W-1:0]   stage_q, stage_d, shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]           dp_stage_q, dp_stage_d, dp_shadow_q, dp_shadow_d;
  logic                            pending_q, pending_d;
  logic                            en_q, en_d, dp_q, dp_d, frame_q, frame_d, ack_q, ack_d;
  logic [SEG_W-1:0]                seg_q, seg_d;
  logic [DIGIT_W-1:0]              cur_digit;
  logic [SEG_W-1:0]                cur_seg;
  logic [NUM_DIGITS-1:0]           lz_blank;
  logic                            idle, ld_idle, ld_frame, lit;

  bcd_to_seg7 u_enc (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Slot sequencing: IDLE -> BLANK gap -> SHOW, advancing the digit index at the end of each slot
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    frame_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: state_d = (cnt_q == CNT_W'(BLANK_CYCLES - 1)) ? SHOW : BLANK;
        SHOW: if (cnt_q == CNT_W'(DIV - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          frame_d = (idx_q == 2'd3);
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffering: stage on load, commit at a frame boundary or straight away while idle
  always_comb begin
    idle        = (state_q == IDLE);
    ld_idle     = idle && (load || pending_q);
    ld_frame    = frame_d && pending_q;
    ack_d       = ld_idle || ld_frame;
    stage_d     = load ? digits : stage_q;
    dp_stage_d  = load ? dp_mask : dp_stage_q;
    pending_d   = !ld_idle && (load || (pending_q && !ld_frame));
    shadow_d    = (ld_idle && load) ? digits : ack_d ? stage_q : shadow_q;
    dp_shadow_d = (ld_idle && load) ? dp_mask : ack_d ? dp_stage_q : dp_shadow_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Suppress zeros to the left of the most significant nonzero digit; digit 0 always shows
  always_comb begin
    lz_blank[3] = (shadow_d[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (shadow_d[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (shadow_d[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
  end
`else
  assign lz_blank = '0;
`endif

  // Output data for the digit that will be selected next cycle, so seg/dp settle during the blank gap
  always_comb begin
    lit       = (state_d != IDLE);
    cur_digit = shadow_d[{idx_d, 2'b00} +: DIGIT_W];
    en_d      = (state_d == SHOW);
    seg_d     = (lit && !lz_blank[idx_d]) ? cur_seg : '0;
    dp_d      = lit && dp_shadow_d[idx_d];
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      dp_stage_q  <= '0;
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      pending_q   <= 1'b0;
      en_q        <= 1'b0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      frame_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      dp_stage_q  <= dp_stage_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      pending_q   <= pending_d;
      en_q        <= en_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
    end
  end

  assign a          = idx_q[1];
  assign b          = idx_q[0];
  assign en         = en_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_q;
  assign load_ack   = ack_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed scoreboard bench for digit_scan_ctrl with DIV=8, BLANK_CYCLES=2
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        a, b, en, dp, frame_done, load_ack;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t sb[$];

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  digit_scan_ctrl #(.DIV(8), .BLANK_CYCLES(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .a          (a),
    .b          (b),
    .en         (en),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done),
    .load_ack   (load_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] expseg(input logic [15:0] d, input logic [1:0] i);
    logic [3:0] n;
    n = d[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if ((i == 2'd3 && d[15:12] == 4'h0) || (i == 2'd2 && d[15:8] == 8'h0) ||
        (i == 2'd1 && d[15:4] == 12'h0))
      return 7'h00;
`endif
    return tbl[n];
  endfunction

  task automatic step(input string tag, input logic [12:0] v);
    exp_t e;
    logic [12:0] got;
    sb.push_back('{tag, v});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    got = {a, b, en, seg, dp, frame_done, load_ack};
    n_cmp++;
    assert (got === e.v) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", e.tag, got, e.v);
    end
  endtask

  task automatic slot(input logic [1:0] i, input logic [15:0] dg, input logic [3:0] dm,
                      input logic f, input logic k, input int c0, input int c1);
    for (int c = c0; c < c1; c++)
      step($sformatf("slot%0d_c%0d", i, c),
           {i, (c >= 2), expseg(dg, i), dm[i], (c == 0) && f, (c == 0) && k});
  endtask

  task automatic frame(input logic [15:0] dg, input logic [3:0] dm, input logic f, input logic k);
    slot(2'd0, dg, dm, f, k, 0, 8);
    for (int s = 1; s < 4; s++) slot(2'(s), dg, dm, 1'b0, 1'b0, 0, 8);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; digits = '0; dp_mask = '0;
    for (int r = 0; r < 3; r++) step("reset", 13'h0);
    rst = 1'b0;
    frame(16'h0000, 4'h0, 1'b0, 1'b0);
    slot(2'd0, 16'h0000, 4'h0, 1'b1, 1'b0, 0, 1);

    enable = 1'b0;
    step("idle0", 13'h0);
    step("idle1", 13'h0);
    load = 1'b1; digits = 16'h4321;
    step("idle_load_ack", 13'h1);
    load = 1'b0;
    step("idle_after_ack", 13'h0);
    enable = 1'b1;
    frame(16'h4321, 4'h0, 1'b0, 1'b0);

    slot(2'd0, 16'h4321, 4'h0, 1'b1, 1'b0, 0, 3);
    load = 1'b1; digits = 16'hAAAA;
    slot(2'd0, 16'h4321, 4'h0, 1'b0, 1'b0, 3, 4);
    load = 1'b0;
    slot(2'd0, 16'h4321, 4'h0, 1'b0, 1'b0, 4, 5);
    load = 1'b1; digits = 16'h0F0F;
    slot(2'd0, 16'h4321, 4'h0, 1'b0, 1'b0, 5, 6);
    load = 1'b0;
    slot(2'd0, 16'h4321, 4'h0, 1'b0, 1'b0, 6, 8);
    for (int s = 1; s < 4; s++) slot(2'(s), 16'h4321, 4'h0, 1'b0, 1'b0, 0, 8);

    slot(2'd0, 16'h0F0F, 4'h0, 1'b1, 1'b1, 0, 8);
    slot(2'd1, 16'h0F0F, 4'h0, 1'b0, 1'b0, 0, 8);
    slot(2'd2, 16'h0F0F, 4'h0, 1'b0, 1'b0, 0, 2);
    load = 1'b1; digits = 16'h7777;
    slot(2'd2, 16'h0F0F, 4'h0, 1'b0, 1'b0, 2, 3);
    load = 1'b0;
    slot(2'd2, 16'h0F0F, 4'h0, 1'b0, 1'b0, 3, 5);
    enable = 1'b0;
    step("enable_drop", 13'h0);
    enable = 1'b1;
    frame(16'h7777, 4'h0, 1'b0, 1'b1);

    load = 1'b1; digits = 16'h1234;
    slot(2'd0, 16'h7777, 4'h0, 1'b1, 1'b0, 0, 1);
    load = 1'b0;
    slot(2'd0, 16'h7777, 4'h0, 1'b0, 1'b0, 1, 8);
    for (int s = 1; s < 4; s++) slot(2'(s), 16'h7777, 4'h0, 1'b0, 1'b0, 0, 8);

    slot(2'd0, 16'h1234, 4'h0, 1'b1, 1'b1, 0, 1);
    load = 1'b1; digits = 16'h0050; dp_mask = 4'b1000;
    slot(2'd0, 16'h1234, 4'h0, 1'b0, 1'b0, 1, 2);
    load = 1'b0;
    slot(2'd0, 16'h1234, 4'h0, 1'b0, 1'b0, 2, 8);
    for (int s = 1; s < 4; s++) slot(2'(s), 16'h1234, 4'h0, 1'b0, 1'b0, 0, 8);
    slot(2'd0, 16'h0050, 4'b1000, 1'b1, 1'b1, 0, 8);
    slot(2'd1, 16'h0050, 4'b1000, 1'b0, 1'b0, 0, 8);
    slot(2'd2, 16'h0050, 4'b1000, 1'b0, 1'b0, 0, 8);
    slot(2'd3, 16'h0050, 4'b1000, 1'b0, 1'b0, 0, 3);
    load = 1'b1; digits = 16'h9999; dp_mask = 4'b1111;
    slot(2'd3, 16'h0050, 4'b1000, 1'b0, 1'b0, 3, 4);
    load = 1'b0;
    rst = 1'b1;
    step("rst_mid", 13'h0);
    rst = 1'b0;
    frame(16'h0000, 4'h0, 1'b0, 1'b0);
    slot(2'd0, 16'h0000, 4'h0, 1'b1, 1'b0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed 4-digit seven-segment scan controller.
- Sits directly upstream of the team's 2-to-4 active-low digit decoder and drives that decoder's a, b and en inputs.
- Cycles through four digit slots, inserts a blanking gap around every select change to prevent ghosting, and produces segment data for the currently selected digit.
- Digit data is double-buffered; new values take effect only on frame boundaries.

Parameters:
- DIV, 50000: clock cycles per digit slot. Legal range: BLANK_CYCLES < DIV.
- BLANK_CYCLES, 2: cycles at the start of each slot during which en is held low. Must be ≥ 1.
- CNT_W, 16: width of the slot cycle counter. Must satisfy 2^CNT_W ≥ DIV.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  scan enable; low forces IDLE.
- load  input  1  one-cycle strobe that captures digits and dp_mask.
- digits  input  16  four 4-bit hex digits; digit k = digits[4k+3:4k].
- dp_mask  input  4  decimal point per digit, active-high.
- a  output  1  decoder select MSB.
- b  output  1  decoder select LSB.
- en  output  1  decoder enable; high = selected digit lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  output  1  decimal point, active-high.
- frame_done  output  1  one-cycle pulse at each frame boundary.
- load_ack  output  1  one-cycle pulse when staged data is copied into the shadow registers.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports clk and rst.
- Reset values:
  - a=0, b=0, en=0, seg=0, dp=0, frame_done=0, load_ack=0.
  - Shadow, staging and counter registers = 0; pending flag = 0.
  - State = IDLE, idx = 0.
- Registered outputs: every output is registered. Digit index idx = {a,b}, so idx 0 drives decoder y[0], idx 3 drives y[3].
- State IDLE:
  - en=0, seg=0, idx=0, cnt=0.
  - When enable=1, next state is BLANK with idx=0 and cnt=0.
- State BLANK:
  - en=0. a and b already show the new idx. seg/dp are updated to the new digit in the BLANK cycles.
  - cnt increments each cycle. When cnt==BLANK_CYCLES-1, next state is SHOW.
- State SHOW:
  - en=1. cnt increments each cycle.
  - When cnt==DIV-1: cnt←0, idx←idx+1 (wraps 3→0), next state is BLANK.
- Slot timing: each slot is exactly DIV cycles, of which DIV−BLANK_CYCLES cycles have en=1.
- Frame boundary:
  - Defined as the SHOW→BLANK transition with idx==3.
  - frame_done is high for exactly one cycle, the first BLANK cycle of idx 0.
- Load handshake:
  - A load strobe captures digits and dp_mask into the staging registers and sets pending.
  - Multiple loads before a boundary: the last one wins.
  - At a frame boundary with pending=1: shadow←staging, pending←0, and load_ack pulses in the same cycle as frame_done. Idx 0 of the new frame already displays the new data.
  - In IDLE, pending data is applied on the next cycle, with load_ack and no frame_done.
  - load in the same cycle as a boundary: the strobe's data is staged and applied at the following boundary. The shadow takes the previously staged value, if any.
- enable deasserted mid-frame:
  - Next cycle: IDLE, en=0, seg=0, idx=0. No frame_done.
  - Pending data is retained and applied per the IDLE rule.
- rst mid-operation: all state returns to reset values on the next edge. Staged data is lost.
- seg encoding: hex 0–F, standard patterns. Examples: 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined:
  - Digit 3 is suppressed (seg=0) if it is 0.
  - Digit 2 is suppressed if digits 3 and 2 are both 0.
  - Digit 1 is suppressed if digits 3, 2 and 1 are all 0.
  - Digit 0 is never suppressed. dp is unaffected by suppression.
- Undefined: every digit is always shown.

Decomposition:
- Shared package digit_scan_pkg contains:
  - state enum {IDLE, BLANK, SHOW};
  - NUM_DIGITS=4, DIGIT_W=4, SEG_W=7;
  - the SEG_* hex pattern constants.
- One sub-module, bcd_to_seg7: purely combinational hex-to-segment encoder, instantiated once on the shadow-digit mux output.

Test Plan (DIV=8, BLANK_CYCLES=2):
- Reset with enable=1 held: all outputs 0 during rst. First cycle after release is BLANK, idx=0. en rises 2 cycles later. Slots are 8 cycles with 6 en-high cycles. {a,b} sequence is 0,1,2,3,0.
- load digits=16'h4321 in IDLE, then enable: load_ack one cycle after load. Slot 0 seg=7'h06, slot 1 seg=7'h5B, slot 2 seg=7'h4F, slot 3 seg=7'h66.
- Two loads (16'hAAAA then 16'h0F0F) mid-frame: old data until the boundary. Then frame_done and load_ack coincide, and the new frame shows F,0,F,0 (slot 0 seg=7'h71).
- enable dropped in slot 2, SHOW cycle 3: next cycle en=0, idx=0, seg=0, no frame_done. Re-enable restarts at idx 0 BLANK.
- With LEADING_ZERO_BLANK_EN, digits=16'h0050 and dp_mask=4'b1000: slots 3 and 2 have seg=0 (slot 3 keeps dp=1), slot 1 seg=7'h6D, slot 0 seg=7'h3F.
- rst asserted in slot 3 with load pending: outputs zero the next cycle. After release, the display shows 0000 and there is no load_ack.
